node_turn_sequencer: RTL and testbench

//   Route-level controller that sits between the PID/threshold line follower and the motor PWM driver.
//   It debounces node detection (all three LFA channels on black) and looks up the next action in a

---
 rtl/line_follow_pkg.sv | 40 ++++
 rtl/node_detector.sv | 59 +++++
 rtl/node_turn_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_node_turn_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_follow_pkg.sv
// Shared types and constants for the line-follower route controller.
package line_follow_pkg;

    // Route table action codes; 5..7 are reserved and end the route in FAULT.
    localparam logic [2:0] ACT_STRAIGHT = 3'd0;
    localparam logic [2:0] ACT_LEFT     = 3'd1;
    localparam logic [2:0] ACT_RIGHT    = 3'd2;
    localparam logic [2:0] ACT_UTURN    = 3'd3;
    localparam logic [2:0] ACT_STOP     = 3'd4;

    // Motor direction pairs as {a, b}.
    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;
    localparam logic [1:0] DIR_OFF = 2'b00;

    // Duty cycles used by the manoeuvres.
    localparam logic [3:0] DC_STRAIGHT = 4'd8;
    localparam logic [3:0] DC_PIVOT    = 4'd6;

    // Default sensor thresholds (12-bit ADC counts).
    localparam logic [11:0] DEF_THRESH_HI = 12'd1000;
    localparam logic [11:0] DEF_THRESH_LO = 12'd200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLLOW,
        ST_DISPATCH,
        ST_BLIND,
        ST_SEEK,
        ST_EXIT,
        ST_DONE,
        ST_FAULT
    } state_e;

    // States in which the robot is parked and the route table may be rewritten.
    function automatic logic is_rest_state(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAULT);
    endfunction

endpackage

// File: rtl/node_detector.sv
// Threshold compare plus debounced, re-armed node detection.
module node_detector
    import line_follow_pkg::*;
#(
    parameter logic [11:0] THRESH_HI = DEF_THRESH_HI,
    parameter logic [11:0] THRESH_LO = DEF_THRESH_LO,
    parameter int          DEBOUNCE  = 3
) (
    input  logic        clk_3125KHz,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] left,
    input  logic [11:0] middle,
    input  logic [11:0] right,
    output logic        node_on,
    output logic        centred,
    output logic        node_pulse
);

    localparam logic [1:0] CNT_LAST = 2'(DEBOUNCE - 1);

    logic [1:0] cnt_reg, cnt_next;
    logic       armed_reg, armed_next;

    assign node_on = (left > THRESH_HI) && (middle > THRESH_HI) && (right > THRESH_HI);
    assign centred = (middle > THRESH_HI) && (left < THRESH_LO) && (right < THRESH_LO);

    // Count consecutive node cycles while enabled; a confirmed node disarms
    // detection until the sensors have seen at least one non-node cycle.
    always_comb begin
        cnt_next   = 2'd0;
        armed_next = armed_reg;
        node_pulse = 1'b0;
        if (!node_on) begin
            armed_next = 1'b1;
        end
        if (en && armed_reg && node_on) begin
            if (cnt_reg == CNT_LAST) begin
                node_pulse = 1'b1;
                armed_next = 1'b0;
            end else begin
                cnt_next = cnt_reg + 2'd1;
            end
        end
    end

    // Debounce counter and arm flag; starts disarmed so a robot parked on a
    // node does not fire on its first FOLLOW cycles.
    always_ff @(posedge clk_3125KHz) begin
        if (!rst_n) begin
            cnt_reg   <= 2'd0;
            armed_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            armed_reg <= armed_next;
        end
    end

endmodule

// File: rtl/node_turn_sequencer.sv
// Route-level sequencer between the line follower and the motor PWM driver.
module node_turn_sequencer
    import line_follow_pkg::*;
#(
    parameter int          ROUTE_LEN = 12,
    parameter logic [11:0] THRESH_HI = DEF_THRESH_HI,
    parameter logic [11:0] THRESH_LO = DEF_THRESH_LO,
    parameter int          DEBOUNCE  = 3,
    parameter int          TURN_MIN  = 15625,
    parameter int          TURN_MAX  = 1562500
) (
    input  logic        clk_3125KHz,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] left,
    input  logic [11:0] middle,
    input  logic [11:0] right,
    input  logic        lf_m1_a,
    input  logic        lf_m1_b,
    input  logic        lf_m2_a,
    input  logic        lf_m2_b,
    input  logic [3:0]  lf_dc1,
    input  logic [3:0]  lf_dc2,
    input  logic        route_wr_en,
    input  logic [3:0]  route_wr_addr,
    input  logic [2:0]  route_wr_data,
    output logic        m1_a,
    output logic        m1_b,
    output logic        m2_a,
    output logic        m2_b,
    output logic [3:0]  dc1,
    output logic [3:0]  dc2,
    output logic [3:0]  node_idx,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    localparam logic [3:0]  LAST_IDX   = 4'(ROUTE_LEN - 1);
    localparam logic [20:0] BLIND_LAST = 21'(TURN_MIN - 1);
    localparam logic [20:0] UTURN_LAST = 21'(2 * TURN_MIN - 1);
    localparam logic [20:0] SEEK_LAST  = 21'(TURN_MAX - 1);

    state_e      state_reg, state_next;
    logic [20:0] turn_cnt_reg, turn_cnt_next;
    logic [2:0]  act_reg, act_next;
    logic [3:0]  node_idx_next;
    logic        advance;
    logic [2:0]  route_mem [16];
    logic [2:0]  route_rd_reg;
    logic [1:0]  m1_next, m2_next;
    logic [3:0]  dc1_next, dc2_next;
    logic        node_on, centred, node_pulse;

    node_detector #(
        .THRESH_HI (THRESH_HI),
        .THRESH_LO (THRESH_LO),
        .DEBOUNCE  (DEBOUNCE)
    ) u_node_detector (
        .clk_3125KHz (clk_3125KHz),
        .rst_n       (rst_n),
        .en          (state_reg == ST_FOLLOW),
        .left        (left),
        .middle      (middle),
        .right       (right),
        .node_on     (node_on),
        .centred     (centred),
        .node_pulse  (node_pulse)
    );

    // Next-state logic; pin values are derived from the state being entered
    // so pins change on the same edge as the state.
    always_comb begin
        state_next    = state_reg;
        turn_cnt_next = turn_cnt_reg + 21'd1;
        act_next      = act_reg;
        node_idx_next = node_idx;
        advance       = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start) begin
                    state_next    = ST_FOLLOW;
                    node_idx_next = 4'd0;
                end
            end
            ST_FOLLOW: begin
                if (node_pulse) state_next = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                act_next = route_rd_reg;
                case (route_rd_reg)
                    ACT_STRAIGHT:                  state_next = ST_EXIT;
                    ACT_LEFT, ACT_RIGHT, ACT_UTURN: state_next = ST_BLIND;
                    ACT_STOP:                      state_next = ST_DONE;
                    default:                       state_next = ST_FAULT;
                endcase
            end
            ST_BLIND: begin
                if (turn_cnt_reg == ((act_reg == ACT_UTURN) ? UTURN_LAST : BLIND_LAST)) begin
                    state_next = ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (centred) begin
                    advance = 1'b1;
                end else if (turn_cnt_reg == SEEK_LAST) begin
                    state_next = ST_FAULT;
                end
            end
            ST_EXIT: begin
                if (!node_on) advance = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase

        // The last route entry finishes the route; node_idx never wraps.
        if (advance) begin
            if (node_idx == LAST_IDX) begin
                state_next = ST_DONE;
            end else begin
                state_next    = ST_FOLLOW;
                node_idx_next = node_idx + 4'd1;
            end
        end

        if (abort) state_next = ST_IDLE;

        // The turn/seek counter restarts on every state change.
        if (state_next != state_reg) turn_cnt_next = 21'd0;

        m1_next  = DIR_OFF;
        m2_next  = DIR_OFF;
        dc1_next = 4'd0;
        dc2_next = 4'd0;
        case (state_next)
            ST_FOLLOW: begin
                m1_next  = {lf_m1_a, lf_m1_b};
                m2_next  = {lf_m2_a, lf_m2_b};
                dc1_next = lf_dc1;
                dc2_next = lf_dc2;
            end
            ST_DISPATCH: begin
                m1_next  = {m1_a, m1_b};
                m2_next  = {m2_a, m2_b};
                dc1_next = dc1;
                dc2_next = dc2;
            end
            ST_BLIND, ST_SEEK: begin
                m1_next  = (act_next == ACT_LEFT) ? DIR_REV : DIR_FWD;
                m2_next  = (act_next == ACT_LEFT) ? DIR_FWD : DIR_REV;
                dc1_next = DC_PIVOT;
                dc2_next = DC_PIVOT;
            end
            ST_EXIT: begin
                m1_next  = DIR_FWD;
                m2_next  = DIR_FWD;
                dc1_next = DC_STRAIGHT;
                dc2_next = DC_STRAIGHT;
            end
            default: ;
        endcase
    end

    // State, counters and registered output pins.
    always_ff @(posedge clk_3125KHz) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            turn_cnt_reg <= 21'd0;
            act_reg      <= ACT_STOP;
            node_idx     <= 4'd0;
            {m1_a, m1_b} <= DIR_OFF;
            {m2_a, m2_b} <= DIR_OFF;
            dc1          <= 4'd0;
            dc2          <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            turn_cnt_reg <= turn_cnt_next;
            act_reg      <= act_next;
            node_idx     <= node_idx_next;
            {m1_a, m1_b} <= m1_next;
            {m2_a, m2_b} <= m2_next;
            dc1          <= dc1_next;
            dc2          <= dc2_next;
            busy         <= !is_rest_state(state_next);
            done         <= (state_next == ST_DONE);
            fault        <= (state_next == ST_FAULT);
        end
    end

    // Route table; writes land only while parked, reset fills it with STOP.
    always_ff @(posedge clk_3125KHz) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) route_mem[i] <= ACT_STOP;
        end else if (route_wr_en && is_rest_state(state_reg)) begin
            route_mem[route_wr_addr] <= route_wr_data;
        end
    end

    // Registered table read of the current entry; node_idx is stable for
    // several FOLLOW cycles before any DISPATCH consumes it.
    always_ff @(posedge clk_3125KHz) begin
        if (!rst_n) begin
            route_rd_reg <= ACT_STOP;
        end else begin
            route_rd_reg <= route_mem[node_idx];
        end
    end

endmodule

// File: tb/tb_node_turn_sequencer.sv
// Self-checking bench for node_turn_sequencer with a route-level reference model.
module tb_node_turn_sequencer;

    localparam int ROUTE_LEN = 4;
    localparam int TURN_MIN  = 100;
    localparam int TURN_MAX  = 400;

    localparam logic [11:0] PINS_OFF = 12'b00_00_0000_0000;
    localparam logic [11:0] PIV_L    = 12'b01_10_0110_0110;
    localparam logic [11:0] PIV_R    = 12'b10_01_0110_0110;
    localparam logic [11:0] FWD8     = 12'b10_10_1000_1000;
    localparam logic [2:0]  S_BUSY   = 3'b100;
    localparam logic [2:0]  S_DONE   = 3'b010;
    localparam logic [2:0]  S_FAULT  = 3'b001;
    localparam logic [2:0]  S_IDLE   = 3'b000;

    logic        clk_3125KHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] left = 12'd0, middle = 12'd0, right = 12'd0;
    logic [11:0] lf_vec = 12'd0;
    logic        lf_m1_a, lf_m1_b, lf_m2_a, lf_m2_b;
    logic [3:0]  lf_dc1, lf_dc2;
    logic        route_wr_en = 1'b0;
    logic [3:0]  route_wr_addr = 4'd0;
    logic [2:0]  route_wr_data = 3'd0;
    logic        m1_a, m1_b, m2_a, m2_b;
    logic [3:0]  dc1, dc2, node_idx;
    logic        busy, done, fault;

    int n_vec = 0;
    int n_err = 0;

    assign {lf_m1_a, lf_m1_b, lf_m2_a, lf_m2_b, lf_dc1, lf_dc2} = lf_vec;

    always #160 clk_3125KHz = ~clk_3125KHz;

    node_turn_sequencer #(
        .ROUTE_LEN (ROUTE_LEN),
        .TURN_MIN  (TURN_MIN),
        .TURN_MAX  (TURN_MAX)
    ) dut (
        .clk_3125KHz   (clk_3125KHz),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .left          (left),
        .middle        (middle),
        .right         (right),
        .lf_m1_a       (lf_m1_a),
        .lf_m1_b       (lf_m1_b),
        .lf_m2_a       (lf_m2_a),
        .lf_m2_b       (lf_m2_b),
        .lf_dc1        (lf_dc1),
        .lf_dc2        (lf_dc2),
        .route_wr_en   (route_wr_en),
        .route_wr_addr (route_wr_addr),
        .route_wr_data (route_wr_data),
        .m1_a          (m1_a),
        .m1_b          (m1_b),
        .m2_a          (m2_a),
        .m2_b          (m2_b),
        .dc1           (dc1),
        .dc2           (dc2),
        .node_idx      (node_idx),
        .busy          (busy),
        .done          (done),
        .fault         (fault)
    );

    function automatic logic [11:0] pins();
        return {m1_a, m1_b, m2_a, m2_b, dc1, dc2};
    endfunction

    function automatic logic [2:0] status();
        return {busy, done, fault};
    endfunction

    task automatic tick();
        @(posedge clk_3125KHz);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic sense(input logic [11:0] l, input logic [11:0] m, input logic [11:0] r);
        left = l; middle = m; right = r;
    endtask

    task automatic sense_node();   sense(12'd1500, 12'd1500, 12'd1500); endtask
    task automatic sense_centre(); sense(12'd100,  12'd1500, 12'd100);  endtask
    task automatic sense_lost();   sense(12'd100,  12'd100,  12'd100);  endtask
    task automatic new_lf();       lf_vec = 12'($urandom);              endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; route_wr_en = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [2:0] d);
        route_wr_en = 1'b1; route_wr_addr = a; route_wr_data = d;
        tick();
        route_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Three node samples confirm a node; the third edge enters DISPATCH.
    task automatic confirm_node();
        sense_node();
        ticks(3);
    endtask

    task automatic test_reset();
        sense_lost();
        lf_vec = 12'hFFF;
        do_reset();
        n_vec++; if (pins() !== PINS_OFF) begin n_err++; $display("FAIL reset_pins got %h want %h", pins(), PINS_OFF); end
        n_vec++; if (status() !== S_IDLE) begin n_err++; $display("FAIL reset_status got %b want %b", status(), S_IDLE); end
        n_vec++; if (node_idx !== 4'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", node_idx); end
        sense_centre();
        pulse_start();
        n_vec++; if (status() !== S_BUSY) begin n_err++; $display("FAIL reset_start_busy got %b want %b", status(), S_BUSY); end
        confirm_node();
        tick();
        $display("reset: entry0 default dispatched, status %b", status());
        n_vec++; if (status() !== S_DONE) begin n_err++; $display("FAIL reset_entry_stop got %b want %b", status(), S_DONE); end
        n_vec++; if (pins() !== PINS_OFF) begin n_err++; $display("FAIL reset_done_pins got %h want %h", pins(), PINS_OFF); end
    endtask

    task automatic test_left_turn();
        logic [11:0] held;
        int          piv_cnt;
        do_reset();
        write_entry(4'd0, 3'd1);
        write_entry(4'd1, 3'd4);
        sense_centre();
        new_lf();
        pulse_start();
        n_vec++; if (pins() !== lf_vec) begin n_err++; $display("FAIL left_follow got %h want %h", pins(), lf_vec); end
        sense_node();
        new_lf();
        held = lf_vec;
        ticks(2);
        new_lf();
        tick();
        n_vec++; if (pins() !== held) begin n_err++; $display("FAIL left_dispatch_hold got %h want %h", pins(), held); end
        tick();
        n_vec++; if (pins() !== PIV_L) begin n_err++; $display("FAIL left_pivot got %h want %h", pins(), PIV_L); end
        piv_cnt = 1;
        for (int i = 0; i < TURN_MIN + 20; i++) begin
            tick();
            if (pins() === PIV_L) piv_cnt++;
        end
        $display("left: pivot held %0d cycles", piv_cnt);
        n_vec++; if (piv_cnt != TURN_MIN + 21) begin n_err++; $display("FAIL left_pivot_len got %0d want %0d", piv_cnt, TURN_MIN + 21); end
        sense_centre();
        new_lf();
        tick();
        n_vec++; if (node_idx !== 4'd1) begin n_err++; $display("FAIL left_idx got %0d want 1", node_idx); end
        n_vec++; if (pins() !== lf_vec) begin n_err++; $display("FAIL left_refollow got %h want %h", pins(), lf_vec); end
        confirm_node();
        tick();
        n_vec++; if (status() !== S_DONE) begin n_err++; $display("FAIL left_done got %b want %b", status(), S_DONE); end
        n_vec++; if (node_idx !== 4'd1) begin n_err++; $display("FAIL left_done_idx got %0d want 1", node_idx); end
    endtask

    task automatic test_straight();
        int ok_cnt;
        do_reset();
        write_entry(4'd0, 3'd0);
        sense_centre();
        pulse_start();
        confirm_node();
        tick();
        ok_cnt = 0;
        for (int i = 0; i < 37; i++) begin
            if (pins() === FWD8 && node_idx === 4'd0) ok_cnt++;
            tick();
        end
        $display("straight: %0d of 37 cycles forward at idx 0", ok_cnt);
        n_vec++; if (ok_cnt != 37) begin n_err++; $display("FAIL straight_hold got %0d want 37", ok_cnt); end
        sense_centre();
        new_lf();
        tick();
        n_vec++; if (node_idx !== 4'd1) begin n_err++; $display("FAIL straight_idx got %0d want 1", node_idx); end
        n_vec++; if (pins() !== lf_vec) begin n_err++; $display("FAIL straight_follow got %h want %h", pins(), lf_vec); end
        ticks(10);
        n_vec++; if (node_idx !== 4'd1) begin n_err++; $display("FAIL straight_single got %0d want 1", node_idx); end
    endtask

    task automatic test_seek_timeout();
        int  n;
        logic seen;
        do_reset();
        write_entry(4'd0, 3'd2);
        sense_centre();
        pulse_start();
        confirm_node();
        tick();
        n_vec++; if (pins() !== PIV_R) begin n_err++; $display("FAIL timeout_pivot got %h want %h", pins(), PIV_R); end
        sense_lost();
        n = 0;
        seen = 1'b0;
        while (!seen && n < TURN_MIN + TURN_MAX + 50) begin
            tick();
            n++;
            if (fault === 1'b1) seen = 1'b1;
        end
        $display("timeout: fault after %0d cycles", n);
        n_vec++; if (!seen || n != TURN_MIN + TURN_MAX) begin n_err++; $display("FAIL timeout_cycles got %0d want %0d", n, TURN_MIN + TURN_MAX); end
        n_vec++; if (pins() !== PINS_OFF) begin n_err++; $display("FAIL timeout_pins got %h want %h", pins(), PINS_OFF); end
        n_vec++; if (status() !== S_FAULT) begin n_err++; $display("FAIL timeout_status got %b want %b", status(), S_FAULT); end
    endtask

    task automatic test_glitch();
        do_reset();
        sense_centre();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (k < 2) sense_node(); else sense_lost();
                new_lf();
                tick();
                n_vec++; if (pins() !== lf_vec || status() !== S_BUSY) begin
                    n_err++; $display("FAIL glitch_pass got %h/%b want %h/%b", pins(), status(), lf_vec, S_BUSY);
                end
            end
        end
        // Parked on a node through reset and start: must not fire until it clears.
        sense_node();
        do_reset();
        pulse_start();
        ticks(10);
        n_vec++; if (status() !== S_BUSY) begin n_err++; $display("FAIL rearm_hold got %b want %b", status(), S_BUSY); end
        sense_centre();
        tick();
        confirm_node();
        tick();
        n_vec++; if (status() !== S_DONE) begin n_err++; $display("FAIL rearm_fire got %b want %b", status(), S_DONE); end
    endtask

    task automatic test_abort();
        do_reset();
        write_entry(4'd0, 3'd1);
        sense_centre();
        pulse_start();
        write_entry(4'd0, 3'd4);
        confirm_node();
        tick();
        n_vec++; if (pins() !== PIV_L) begin n_err++; $display("FAIL abort_busy_write got %h want %h", pins(), PIV_L); end
        ticks(TURN_MIN + 5);
        abort = 1'b1;
        route_wr_en = 1'b1; route_wr_addr = 4'd0; route_wr_data = 3'd0;
        tick();
        abort = 1'b0;
        route_wr_en = 1'b0;
        n_vec++; if (pins() !== PINS_OFF) begin n_err++; $display("FAIL abort_pins got %h want %h", pins(), PINS_OFF); end
        n_vec++; if (status() !== S_IDLE) begin n_err++; $display("FAIL abort_status got %b want %b", status(), S_IDLE); end
        sense_centre();
        pulse_start();
        confirm_node();
        tick();
        n_vec++; if (pins() !== PIV_L) begin n_err++; $display("FAIL abort_table got %h want %h", pins(), PIV_L); end
    endtask

    // Random routes; the model walks the table by the route rules and
    // decides every expected pin and flag value on its own.
    task automatic test_random();
        logic [2:0]  tbl [ROUTE_LEN];
        logic [11:0] held, exp_piv;
        logic [3:0]  idx;
        logic        finished;
        int          blind;
        do_reset();
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < ROUTE_LEN; a++) begin
                case ($urandom_range(0, 9))
                    0, 1, 9: tbl[a] = 3'd0;
                    2, 3:    tbl[a] = 3'd1;
                    4, 5:    tbl[a] = 3'd2;
                    6:       tbl[a] = 3'd3;
                    7:       tbl[a] = 3'd4;
                    default: tbl[a] = 3'($urandom_range(5, 7));
                endcase
                write_entry(4'(a), tbl[a]);
            end
            sense_centre();
            new_lf();
            pulse_start();
            idx = 4'd0;
            finished = 1'b0;
            while (!finished) begin
                repeat ($urandom_range(1, 4)) begin
                    new_lf();
                    tick();
                    n_vec++; if (pins() !== lf_vec || node_idx !== idx) begin
                        n_err++; $display("FAIL rnd_follow got %h/%0d want %h/%0d", pins(), node_idx, lf_vec, idx);
                    end
                end
                held = lf_vec;
                sense_node();
                ticks(2);
                new_lf();
                tick();
                n_vec++; if (pins() !== held) begin n_err++; $display("FAIL rnd_hold got %h want %h", pins(), held); end
                tick();
                $display("route %0d node %0d action %0d", r, idx, tbl[idx]);
                if (tbl[idx] == 3'd4) begin
                    n_vec++; if (status() !== S_DONE || pins() !== PINS_OFF) begin
                        n_err++; $display("FAIL rnd_stop got %b/%h want %b/%h", status(), pins(), S_DONE, PINS_OFF);
                    end
                    finished = 1'b1;
                end else if (tbl[idx] > 3'd4) begin
                    n_vec++; if (status() !== S_FAULT || pins() !== PINS_OFF) begin
                        n_err++; $display("FAIL rnd_reserved got %b/%h want %b/%h", status(), pins(), S_FAULT, PINS_OFF);
                    end
                    finished = 1'b1;
                end else begin
                    if (tbl[idx] == 3'd0) begin
                        n_vec++; if (pins() !== FWD8) begin n_err++; $display("FAIL rnd_exit got %h want %h", pins(), FWD8); end
                        ticks($urandom_range(0, 5));
                    end else begin
                        blind   = (tbl[idx] == 3'd3) ? 2 * TURN_MIN : TURN_MIN;
                        exp_piv = (tbl[idx] == 3'd1) ? PIV_L : PIV_R;
                        n_vec++; if (pins() !== exp_piv) begin n_err++; $display("FAIL rnd_pivot got %h want %h", pins(), exp_piv); end
                        sense_centre();
                        ticks(blind);
                        n_vec++; if (pins() !== exp_piv) begin n_err++; $display("FAIL rnd_blind_len got %h want %h", pins(), exp_piv); end
                    end
                    sense_centre();
                    new_lf();
                    tick();
                    if (idx == 4'(ROUTE_LEN - 1)) begin
                        n_vec++; if (status() !== S_DONE || node_idx !== idx) begin
                            n_err++; $display("FAIL rnd_last got %b/%0d want %b/%0d", status(), node_idx, S_DONE, idx);
                        end
                        finished = 1'b1;
                    end else begin
                        idx = idx + 4'd1;
                        n_vec++; if (status() !== S_BUSY || node_idx !== idx || pins() !== lf_vec) begin
                            n_err++; $display("FAIL rnd_advance got %b/%0d/%h want %b/%0d/%h", status(), node_idx, pins(), S_BUSY, idx, lf_vec);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_left_turn();
        test_straight();
        test_seek_timeout();
        test_glitch();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(320 * 90000);
        $display("FAIL watchdog expired after 90000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
